qam_symbol_mapper: RTL and testbench
====================================

Name: qam_symbol_mapper

Overview:
Parametrised, multi-mode successor to the fixed 16-QAM constellation mapper. Accepts a serial bit stream under a valid/ready handshake and gathers 1/2/4/6 bits per symbol according to a runtime mode (BPSK/QPSK/16-QAM/64-QAM). Each completed symbol word is mapped to signed, scaled, sign-extended I/Q values and held in a registered output stage with valid/ready backpressure. Sits between the bit source (scrambler/serialiser) and the pulse-shaping/upconversion path.

Parameters:
OUT_W, 32, width of signed symbol_I/symbol_Q outputs; must be >= 4+SCALE_SHIFT.
SCALE_SHIFT, 0, left shift applied to the odd-integer amplitude (amplitude = (2m+1) << SCALE_SHIFT).
MAX_BPS, 6, maximum bits per symbol supported (fixed at 6; sizes the gather register).

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
mode  in  2  0=BPSK, 1=QPSK, 2=16-QAM, 3=64-QAM; sampled only at symbol start
flush  in  1  synchronous; discards any partially gathered symbol
bit_in  in  1  serial data bit
bit_valid  in  1  bit_in valid
bit_ready  out  1  mapper can accept a bit this cycle
sym_valid  out  1  symbol_I/symbol_Q hold a valid symbol
sym_ready  in  1  downstream accepts symbol
symbol_I  out  OUT_W  signed in-phase amplitude
symbol_Q  out  OUT_W  signed quadrature amplitude
busy  out  1  partial symbol in gather register (bit count != 0)

Behaviour:
- Reset (rst_n low, async): bit count=0, gather reg=0, latched mode=0, sym_valid=0, symbol_I=0, symbol_Q=0, busy=0. Reset mid-symbol discards partial bits and any held output.
- bit_ready = !sym_valid || sym_ready (combinational). A bit is accepted when bit_valid && bit_ready.
- Bits-per-symbol N: BPSK 1, QPSK 2, 16-QAM 4, 64-QAM 6. Mode latched on the accepted bit when count==0; mode changes mid-symbol are ignored until the next symbol.
- First accepted bit is word MSB b[N-1]; each accepted bit shifts in at LSB; count increments.
- On the accepted bit making count==N: count->0, output regs load mapped values, sym_valid=1 next cycle (latency: 1 cycle after last bit accepted).
- Output handshake: sym_valid clears when sym_ready && sym_valid unless a new symbol completes in the same cycle, in which case sym_valid stays 1 and data updates (back-to-back, no bubble). While sym_valid && !sym_ready, outputs are stable and bit_ready=0.
- Mapping (natural binary, not Gray), N=2k for k>=1: I axis = bits b[N-1], b[N-3], ..., b[1]; Q axis = b[N-2], ..., b[0]. First axis bit is sign (1 = negative); remaining k-1 bits form m (MSB first). Amplitude = (2m+1)<<SCALE_SHIFT, two's-complement negated if sign=1, sign-extended to OUT_W. QPSK: m=0, amplitude ±1.
- BPSK: I = +1 (bit 0) or -1 (bit 1), scaled; Q = 0.
- flush: count->0, gather reg cleared; does not affect a held output symbol. flush with an accepted bit in the same cycle: flush wins, bit dropped (bit_ready still reports handshake; bench must not count it).
- busy = (count != 0).

Decomposition:
- Package qam_pkg: mode encodings (MODE_BPSK..MODE_QAM64), function bits_per_symbol(mode), MAX_BPS constant, count width.
- Sub-module qam_axis_map (combinational): inputs sign bit, magnitude bits (up to 2), bit count k; output OUT_W signed amplitude with SCALE_SHIFT. Instantiated for I and Q; BPSK Q forced to 0 in the top level.

Test Plan:
- 16-QAM, bits 1,0,1,1 (word 1011), sym_ready=1 -> one cycle after 4th bit: sym_valid=1, symbol_I=-3 (0xFFFFFFFD), symbol_Q=+3.
- 64-QAM, bits 1,0,1,1,0,1 (word 101101) -> symbol_I=-5, symbol_Q=+7; QPSK bits 0,1 -> I=+1, Q=-1; BPSK bit 1 -> I=-1, Q=0.
- SCALE_SHIFT=2, 16-QAM word 0000 -> I=+4, Q=+4; word 1111 -> I=-12, Q=-12.
- Backpressure: sym_ready=0 after symbol completes -> sym_valid stays 1, outputs stable, bit_ready=0 for all held cycles; raise sym_ready -> next bit accepted that cycle; continuous streaming with sym_ready=1 yields one symbol per N bits with no bubbles.
- Mode switch 16-QAM->QPSK asserted after 2nd bit -> current symbol still uses 4 bits; following symbol uses 2 bits.
- flush after 3 of 4 bits -> busy=0, no symbol emitted; next 4 bits form a clean symbol. Async reset mid-symbol with sym_valid=1 -> all outputs 0 immediately.

Source files
------------

// File: rtl/qam_pkg.sv
// -----------------------------------------------------------------------------
// qam_pkg
// Shared definitions for the multi-mode QAM symbol mapper:
//   - qam_mode_e      : runtime modulation mode encodings
//   - QAM_MAX_BPS     : largest number of bits gathered into one symbol
//   - CNT_W           : width of the gathered-bit counter
//   - bits_per_symbol : bits needed to complete one symbol in a given mode
// -----------------------------------------------------------------------------
package qam_pkg;

  typedef enum logic [1:0] {
    MODE_BPSK  = 2'd0,
    MODE_QPSK  = 2'd1,
    MODE_QAM16 = 2'd2,
    MODE_QAM64 = 2'd3
  } qam_mode_e;

  localparam int QAM_MAX_BPS = 6;
  localparam int CNT_W       = 3;

  function automatic logic [CNT_W-1:0] bits_per_symbol(input qam_mode_e m);
    logic [CNT_W-1:0] n;
    case (m)
      MODE_BPSK:  n = 3'd1;
      MODE_QPSK:  n = 3'd2;
      MODE_QAM16: n = 3'd4;
      MODE_QAM64: n = 3'd6;
      default:    n = 3'd1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/qam_axis_map.sv
// -----------------------------------------------------------------------------
// qam_axis_map
// Combinational mapping of one constellation axis to a signed amplitude.
// The axis value m (0..2^(k-1)-1) becomes the odd level (2m+1), shifted left
// by SCALE_SHIFT and negated when the sign bit is set.
// Ports:
//   sign_i : axis sign bit, 1 = negative
//   mag_i  : magnitude bits, right-aligned (mag_i[0] is the LSB of m)
//   k_i    : bits per axis (1 = sign only, 2 = one magnitude bit, 3 = two)
//   amp_o  : signed, scaled, sign-extended amplitude
// -----------------------------------------------------------------------------
module qam_axis_map #(
  parameter int OUT_W       = 32,
  parameter int SCALE_SHIFT = 0
) (
  input  logic                    sign_i,
  input  logic [1:0]              mag_i,
  input  logic [1:0]              k_i,
  output logic signed [OUT_W-1:0] amp_o
);

  logic [1:0]       m;
  logic [2:0]       odd;
  logic [OUT_W-1:0] mag_ext;

  // Magnitude bits beyond what the axis width carries are ignored.
  always_comb begin
    m = 2'b00;
    case (k_i)
      2'd2:    m = {1'b0, mag_i[0]};
      2'd3:    m = mag_i;
      default: m = 2'b00;
    endcase
  end

  assign odd     = {m, 1'b1};
  assign mag_ext = OUT_W'(odd) << SCALE_SHIFT;
  assign amp_o   = sign_i ? $signed(-mag_ext) : $signed(mag_ext);

endmodule

// File: rtl/qam_symbol_mapper.sv
// -----------------------------------------------------------------------------
// qam_symbol_mapper
// Gathers a serial bit stream into 1/2/4/6-bit symbol words (BPSK/QPSK/
// 16-QAM/64-QAM, chosen per symbol) and maps each word to signed I/Q
// amplitudes held in a registered output stage.
//
// Handshakes (both sides): a transfer happens on a rising edge where valid
// and ready are both high. Input side: bit_valid/bit_ready, where
// bit_ready = !sym_valid || sym_ready. Output side: sym_valid/sym_ready;
// while sym_valid && !sym_ready the outputs hold and no bits are accepted.
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   mode                : modulation mode, sampled on the first bit of a symbol
//   flush               : drops any partially gathered symbol (wins over a bit)
//   bit_in/bit_valid    : serial input bit and its valid
//   bit_ready           : mapper accepts a bit this cycle
//   sym_valid/sym_ready : output symbol valid / downstream ready
//   symbol_I/symbol_Q   : signed in-phase / quadrature amplitudes
//   busy                : a partial symbol is being gathered
// -----------------------------------------------------------------------------
module qam_symbol_mapper
  import qam_pkg::*;
#(
  parameter int OUT_W       = 32,
  parameter int SCALE_SHIFT = 0,
  parameter int MAX_BPS     = QAM_MAX_BPS
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              mode,
  input  logic                    flush,
  input  logic                    bit_in,
  input  logic                    bit_valid,
  output logic                    bit_ready,
  output logic                    sym_valid,
  input  logic                    sym_ready,
  output logic signed [OUT_W-1:0] symbol_I,
  output logic signed [OUT_W-1:0] symbol_Q,
  output logic                    busy
);

  // The last bit of a symbol is consumed straight from bit_in, so only
  // MAX_BPS-1 earlier bits ever need storing.
  logic [MAX_BPS-2:0]      gather_q, gather_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  qam_mode_e               mode_q, mode_d;
  logic                    sym_valid_q, sym_valid_d;
  logic signed [OUT_W-1:0] sym_i_q, sym_i_d;
  logic signed [OUT_W-1:0] sym_q_q, sym_q_d;

  logic                    accept;
  logic                    complete;
  qam_mode_e               cur_mode;
  logic [CNT_W-1:0]        n_bits;
  logic [CNT_W-1:0]        cnt_inc;
  logic [MAX_BPS-1:0]      word;

  logic                    i_sign, q_sign;
  logic [1:0]              i_mag, q_mag;
  logic [1:0]              axis_k;
  logic signed [OUT_W-1:0] amp_i, amp_q;

  assign bit_ready = !sym_valid_q || sym_ready;
  assign accept    = bit_valid && bit_ready && !flush;

  // A new symbol takes the live mode; a symbol in progress keeps its own.
  assign cur_mode  = (cnt_q == '0) ? qam_mode_e'(mode) : mode_q;
  assign n_bits    = bits_per_symbol(cur_mode);
  assign cnt_inc   = cnt_q + 3'd1;
  assign complete  = accept && (cnt_inc == n_bits);

  // Word as it stands once bit_in is shifted in; MSB-first arrival puts
  // b[N-1] at index N-1 for every N.
  assign word      = {gather_q, bit_in};

  // Axis split: I takes b[N-1], b[N-3], ..., Q takes b[N-2], b[N-4], ...
  // The first bit of each axis is its sign.
  always_comb begin
    i_sign = 1'b0;
    q_sign = 1'b0;
    i_mag  = 2'b00;
    q_mag  = 2'b00;
    axis_k = 2'd1;
    case (cur_mode)
      MODE_BPSK: begin
        i_sign = word[0];
      end
      MODE_QPSK: begin
        i_sign = word[1];
        q_sign = word[0];
      end
      MODE_QAM16: begin
        i_sign = word[3];
        q_sign = word[2];
        i_mag  = {1'b0, word[1]};
        q_mag  = {1'b0, word[0]};
        axis_k = 2'd2;
      end
      MODE_QAM64: begin
        i_sign = word[5];
        q_sign = word[4];
        i_mag  = {word[3], word[1]};
        q_mag  = {word[2], word[0]};
        axis_k = 2'd3;
      end
      default: ;
    endcase
  end

  qam_axis_map #(
    .OUT_W       (OUT_W),
    .SCALE_SHIFT (SCALE_SHIFT)
  ) u_map_i (
    .sign_i (i_sign),
    .mag_i  (i_mag),
    .k_i    (axis_k),
    .amp_o  (amp_i)
  );

  qam_axis_map #(
    .OUT_W       (OUT_W),
    .SCALE_SHIFT (SCALE_SHIFT)
  ) u_map_q (
    .sign_i (q_sign),
    .mag_i  (q_mag),
    .k_i    (axis_k),
    .amp_o  (amp_q)
  );

  // Gather path.
  always_comb begin
    cnt_d    = cnt_q;
    gather_d = gather_q;
    mode_d   = mode_q;
    if (flush) begin
      cnt_d    = '0;
      gather_d = '0;
    end else if (accept) begin
      if (cnt_q == '0) mode_d = cur_mode;
      if (complete) begin
        cnt_d    = '0;
        gather_d = '0;
      end else begin
        cnt_d    = cnt_inc;
        gather_d = word[MAX_BPS-2:0];
      end
    end
  end

  // Output stage: a completing symbol reloads even while the previous one
  // is being taken, so streaming has no bubble.
  always_comb begin
    sym_valid_d = sym_valid_q;
    sym_i_d     = sym_i_q;
    sym_q_d     = sym_q_q;
    if (complete) begin
      sym_valid_d = 1'b1;
      sym_i_d     = amp_i;
      sym_q_d     = (cur_mode == MODE_BPSK) ? '0 : amp_q;
    end else if (sym_ready) begin
      sym_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      gather_q    <= '0;
      mode_q      <= MODE_BPSK;
      sym_valid_q <= 1'b0;
      sym_i_q     <= '0;
      sym_q_q     <= '0;
    end else begin
      cnt_q       <= cnt_d;
      gather_q    <= gather_d;
      mode_q      <= mode_d;
      sym_valid_q <= sym_valid_d;
      sym_i_q     <= sym_i_d;
      sym_q_q     <= sym_q_d;
    end
  end

  assign sym_valid = sym_valid_q;
  assign symbol_I  = sym_i_q;
  assign symbol_Q  = sym_q_q;
  assign busy      = (cnt_q != '0);

endmodule

// File: tb/tb_qam_symbol_mapper.sv
// -----------------------------------------------------------------------------
// tb_qam_symbol_mapper
// Two mapper instances (SCALE_SHIFT 0 and 2) share one stimulus stream.
// A positional bit-list model predicts every output each cycle; directed
// literal checks pin the model to hand-computed constellation points.
// -----------------------------------------------------------------------------
module tb_qam_symbol_mapper;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  mode;
  logic        flush;
  logic        bit_in;
  logic        bit_valid;
  logic        sym_ready;

  logic        bit_ready_0, sym_valid_0, busy_0;
  logic [31:0] sym_i_0, sym_q_0;
  logic        bit_ready_2, sym_valid_2, busy_2;
  logic [31:0] sym_i_2, sym_q_2;

  qam_symbol_mapper #(.OUT_W(32), .SCALE_SHIFT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .flush(flush),
    .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready_0),
    .sym_valid(sym_valid_0), .sym_ready(sym_ready),
    .symbol_I(sym_i_0), .symbol_Q(sym_q_0), .busy(busy_0)
  );

  qam_symbol_mapper #(.OUT_W(32), .SCALE_SHIFT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .flush(flush),
    .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready_2),
    .sym_valid(sym_valid_2), .sym_ready(sym_ready),
    .symbol_I(sym_i_2), .symbol_Q(sym_q_2), .busy(busy_2)
  );

  // ---------------- scoreboard ----------------
  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_bits[$];
  int m_mode;
  bit m_valid;
  int m_i0, m_q0, m_i2, m_q2;

  function automatic int nbits_of(input int md);
    int t[4] = '{1, 2, 4, 6};
    return t[md];
  endfunction

  function automatic int level(input int sgn, input int m, input int sh);
    int a;
    a = (2 * m + 1) * (1 << sh);
    return sgn ? -a : a;
  endfunction

  // bits[0] is the first bit received. I uses positions 0,2,4; Q 1,3,5.
  task automatic model_symbol(input int sh, output int vi, output int vq);
    int n, mi, mq;
    n  = m_bits.size();
    mi = 0;
    mq = 0;
    for (int p = 2; p < n; p += 2) mi = mi * 2 + m_bits[p];
    for (int p = 3; p < n; p += 2) mq = mq * 2 + m_bits[p];
    if (n == 1) begin
      vi = level(m_bits[0], 0, sh);
      vq = 0;
    end else begin
      vi = level(m_bits[0], mi, sh);
      vq = level(m_bits[1], mq, sh);
    end
  endtask

  task automatic model_reset();
    m_bits.delete();
    m_mode  = 0;
    m_valid = 0;
    m_i0 = 0; m_q0 = 0; m_i2 = 0; m_q2 = 0;
  endtask

  // Compare at the falling edge, then advance the model with the inputs
  // that the next rising edge will capture.
  always @(negedge clk) begin
    bit exp_ready, acc, done;
    if (!rst_n) model_reset();
    exp_ready = !m_valid || sym_ready;
    chk("bit_ready",  {31'd0, bit_ready_0}, {31'd0, exp_ready});
    chk("bit_ready2", {31'd0, bit_ready_2}, {31'd0, exp_ready});
    chk("sym_valid",  {31'd0, sym_valid_0}, {31'd0, m_valid});
    chk("sym_valid2", {31'd0, sym_valid_2}, {31'd0, m_valid});
    chk("busy",       {31'd0, busy_0}, {31'd0, m_bits.size() != 0});
    chk("busy2",      {31'd0, busy_2}, {31'd0, m_bits.size() != 0});
    if (m_valid) begin
      chk("sym_I",  sym_i_0, m_i0);
      chk("sym_Q",  sym_q_0, m_q0);
      chk("sym_I2", sym_i_2, m_i2);
      chk("sym_Q2", sym_q_2, m_q2);
    end
    if (rst_n) begin
      acc  = bit_valid && exp_ready;
      done = 0;
      if (flush) begin
        m_bits.delete();
      end else if (acc) begin
        if (m_bits.size() == 0) m_mode = int'(mode);
        m_bits.push_back(int'(bit_in));
        if (m_bits.size() == nbits_of(m_mode)) begin
          done = 1;
          model_symbol(0, m_i0, m_q0);
          model_symbol(2, m_i2, m_q2);
          m_bits.delete();
        end
      end
      if (done) m_valid = 1;
      else if (sym_ready) m_valid = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_bit(input logic b);
    bit_in    = b;
    bit_valid = 1'b1;
    @(posedge clk); #1;
    bit_valid = 1'b0;
  endtask

  task automatic send_word(input int n, input logic [5:0] w);
    for (int i = n - 1; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic idle(input int n);
    bit_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk_sym(input string name, input int i0, input int q0);
    chk({name, "_valid"}, {31'd0, sym_valid_0}, 32'd1);
    chk({name, "_I"}, sym_i_0, i0);
    chk({name, "_Q"}, sym_q_0, q0);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst_n = 1'b0; mode = 2'd0; flush = 1'b0;
    bit_in = 1'b0; bit_valid = 1'b0; sym_ready = 1'b1;
    repeat (2) @(posedge clk); #1;
    chk("rst_valid", {31'd0, sym_valid_0}, 32'd0);
    chk("rst_I",     sym_i_0, 32'd0);
    chk("rst_Q",     sym_q_0, 32'd0);
    chk("rst_busy",  {31'd0, busy_0}, 32'd0);
    rst_n = 1'b1;
    idle(1);

    // Constellation points, streamed back to back.
    mode = 2'd2; send_word(4, 6'b001011);
    chk_sym("q16_1011", -3, 3);
    chk("q16_1011_I2", sym_i_2, -12);
    chk("q16_1011_Q2", sym_q_2, 12);
    mode = 2'd3; send_word(6, 6'b101101);
    chk_sym("q64_101101", -5, 7);
    mode = 2'd1; send_word(2, 6'b000001);
    chk_sym("qpsk_01", 1, -1);
    mode = 2'd0; send_word(1, 6'b000001);
    chk_sym("bpsk_1", -1, 0);
    mode = 2'd2; send_word(4, 6'b000000);
    chk_sym("q16_0000", 1, 1);
    chk("q16_0000_I2", sym_i_2, 4);
    chk("q16_0000_Q2", sym_q_2, 4);
    send_word(4, 6'b001111);
    chk_sym("q16_1111", -3, -3);
    chk("q16_1111_I2", sym_i_2, -12);
    chk("q16_1111_Q2", sym_q_2, -12);
    idle(2);

    // Mode change mid-symbol applies only to the next symbol.
    mode = 2'd2; send_bit(1'b0); send_bit(1'b0);
    mode = 2'd1; send_bit(1'b1); send_bit(1'b0);
    chk_sym("switch_q16", 3, 1);
    send_word(2, 6'b000011);
    chk_sym("switch_qpsk", -1, -1);
    idle(2);

    // Backpressure: held symbol, no bits taken until sym_ready returns.
    sym_ready = 1'b0;
    mode = 2'd2; send_word(4, 6'b000110);
    chk_sym("bp_0110", 3, -1);
    bit_in = 1'b1; bit_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("bp_hold_ready", {31'd0, bit_ready_0}, 32'd0);
      chk_sym("bp_hold", 3, -1);
    end
    sym_ready = 1'b1; #1;
    chk("bp_release_ready", {31'd0, bit_ready_0}, 32'd1);
    @(posedge clk); #1;
    bit_valid = 1'b0;
    chk("bp_taken_busy",  {31'd0, busy_0}, 32'd1);
    chk("bp_taken_valid", {31'd0, sym_valid_0}, 32'd0);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
    chk_sym("bp_1001", -1, 3);
    idle(2);

    // Flush after three bits; the flushing-cycle bit is dropped.
    mode = 2'd2; send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    flush = 1'b1; bit_in = 1'b1; bit_valid = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; bit_valid = 1'b0;
    chk("flush_busy",  {31'd0, busy_0}, 32'd0);
    chk("flush_valid", {31'd0, sym_valid_0}, 32'd0);
    send_word(4, 6'b000100);
    chk_sym("flush_0100", 1, -1);
    idle(2);

    // Asynchronous reset while a symbol is held.
    sym_ready = 1'b0;
    mode = 2'd3; send_word(6, 6'b011010);
    chk_sym("q64_011010", 7, -1);
    idle(1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, sym_valid_0}, 32'd0);
    chk("arst_I",     sym_i_0, 32'd0);
    chk("arst_Q",     sym_q_0, 32'd0);
    chk("arst_busy",  {31'd0, busy_0}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; sym_ready = 1'b1;
    idle(1);

    // Asynchronous reset with a partial symbol.
    mode = 2'd3; send_bit(1'b1); send_bit(1'b0);
    chk("partial_busy", {31'd0, busy_0}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("partial_rst_busy", {31'd0, busy_0}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);
    mode = 2'd2; send_word(4, 6'b001011);
    chk_sym("post_rst_1011", -3, 3);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
